demux1to2_stream: RTL and testbench
===================================

DEMUX1TO2_STREAM -- requirements
Module: demux1to2_stream

Interface
REQ-001 Parameter: WIDTH, default 8, data width of the input and both output channels.
REQ-002 Parameter: DEPTH, default 2, entries per output channel buffer; legal values are 2 and 4.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  WIDTH  input payload.
REQ-006 in_sel  input  1  destination select: 0 routes to channel 0, 1 routes to channel 1; qualified by in_valid.
REQ-007 in_valid  input  1  input beat present.
REQ-008 in_ready  output  1  block can accept the beat addressed by in_sel this cycle.
REQ-009 out0_data / out1_data  output  WIDTH  head entry of the channel buffer.
REQ-010 out0_valid / out1_valid  output  1  channel buffer non-empty.
REQ-011 out0_ready / out1_ready  input  1  downstream accepts the head entry.
REQ-012 cnt0 / cnt1  output  8  number of beats delivered on each channel, modulo 256.

Function
REQ-013 Input transfer occurs when in_valid=1 and in_ready=1 on a rising clk edge.
REQ-014 in_ready SHALL be 1 exactly when the channel buffer selected by the current in_sel is not full; this is combinational on in_sel and occupancy only, never on in_valid.
REQ-015 An accepted beat is written to the tail of the channel buffer chosen by in_sel; the other channel is untouched.
REQ-016 Latency: a beat accepted at edge N appears on outX_data with outX_valid=1 from after edge N; there is no combinational input-to-output path.
REQ-017 Output transfer occurs when outX_valid=1 and outX_ready=1 on a rising edge; the head entry is removed and cntX increments by 1.
REQ-018 Each channel buffer is strictly FIFO; per-channel order equals input acceptance order.
REQ-019 Channels are independent: a full or stalled channel SHALL NOT block beats addressed to the other channel.
REQ-020 Simultaneous push and pop on the same channel in one edge SHALL leave occupancy unchanged; this applies when the buffer is not full.
REQ-021 When full, in_ready=0 for that channel even if outX_ready=1 in the same cycle; there is no pass-through on full.
REQ-022 Pop on an empty buffer is impossible (outX_valid=0); outX_ready is ignored while empty.
REQ-023 outX_data is stable while outX_valid=1 and outX_ready=0.
REQ-024 Buffer read/write pointers wrap modulo DEPTH; occupancy is tracked with one extra bit to distinguish full from empty.
REQ-025 cntX wraps from 255 to 0 with no flag.
REQ-026 Sustained throughput: with both outX_ready=1, the block accepts one beat per cycle indefinitely.

Reset
REQ-027 rst_n=0 SHALL immediately and asynchronously clear both buffers to empty, set out0_valid=out1_valid=0, and set cnt0=cnt1=0.
REQ-028 During reset, in_ready=0; outX_data is don't-care but SHALL be 0.
REQ-029 Reset asserted mid-transfer discards all buffered beats; no beat is delivered after reset release unless it is accepted after release.
REQ-030 Reset release is synchronised to the design's own use: first acceptance is possible on the first rising edge after rst_n rises.

Verification
REQ-031 Routing: out0_ready=out1_ready=1; send 0xA5 with sel=0 and then 0x3C with sel=1 -> out0 shows 0xA5 one cycle later, out1 shows 0x3C one cycle later, cnt0=1, cnt1=1.
REQ-032 Full/backpressure: out0_ready=0; send 0x01, 0x02, 0x03 on sel=0 -> first two accepted, in_ready=0 for the third; raise out0_ready -> the outputs are 0x01, 0x02, then 0x03 in order.
REQ-033 Independence: channel 0 full and stalled; send 0x55 with sel=1 -> in_ready=1, delivered on out1 while out0 holds 0x01.
REQ-034 Throughput/wrap: 300 back-to-back beats alternating sel with both readys=1 -> no stall cycles, cnt0=cnt1=150 mod 256=150, data order preserved.
REQ-035 Reset mid-operation: with 2 beats buffered on each channel, pulse rst_n low asynchronously between edges -> outX_valid=0 and cnt=0 immediately; no stale beat appears after release.
REQ-036 Simultaneous push/pop: channel 1 holding 1 entry, push and pop in the same cycle -> occupancy stays at 1, out1_valid stays 1.

Source files
------------

// File: rtl/demux1to2_stream.sv
// 1-to-2 stream demultiplexer. A registered FIFO sits on each output channel
// so that a stalled channel never blocks beats addressed to the other one.

module demux1to2_stream_chan #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full,
    output logic [7:0]       o_cnt
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    logic [AW:0]                  r_wptr, r_rptr;
    logic [DEPTH-1:0][WIDTH-1:0]  r_mem;
    logic [7:0]                   r_cnt;
    logic                         w_empty, w_pop;

    assign w_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = !w_empty && i_ready;
    assign o_valid = !w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
    assign o_cnt   = r_cnt;

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop) begin
                r_rptr <= r_rptr + (AW+1)'(1);
                r_cnt  <= r_cnt + 8'd1;
            end
        end
    end
endmodule

module demux1to2_stream #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1
);
    localparam int NCH = 2;

    logic [NCH-1:0][WIDTH-1:0] w_out_data;
    logic [NCH-1:0][7:0]       w_cnt;
    logic [NCH-1:0]            w_out_valid, w_out_ready, w_full, w_push;

    // Readiness depends only on the addressed channel's occupancy, and is held
    // low while reset is asserted.
    assign in_ready    = rst_n && !w_full[in_sel];
    assign w_out_ready = {out1_ready, out0_ready};

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        assign w_push[ch] = in_valid && in_ready && (in_sel == 1'(ch));

        demux1to2_stream_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (w_push[ch]),
            .i_data  (in_data),
            .i_ready (w_out_ready[ch]),
            .o_data  (w_out_data[ch]),
            .o_valid (w_out_valid[ch]),
            .o_full  (w_full[ch]),
            .o_cnt   (w_cnt[ch])
        );
    end

    assign out0_data  = w_out_data[0];
    assign out1_data  = w_out_data[1];
    assign out0_valid = w_out_valid[0];
    assign out1_valid = w_out_valid[1];
    assign cnt0       = w_cnt[0];
    assign cnt1       = w_cnt[1];
endmodule

// File: tb/tb_demux1to2_stream.sv
// Directed bench for demux1to2_stream: routing, backpressure, independence,
// same-cycle push/pop, sustained throughput with counter wrap, async reset.

module tb_demux1to2_stream;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_sel, in_valid, in_ready;
    logic [7:0] out0_data, out1_data, cnt0, cnt1;
    logic       out0_valid, out1_valid, out0_ready, out1_ready;

    int checks = 0;
    int errors = 0;

    demux1to2_stream #(.WIDTH(8), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_v0", out0_valid, 0);
        chk("rst_v1", out1_valid, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
        chk("rst_d0", out0_data, 0);
        rst_n = 1'b1;

        // Routing
        out0_ready = 1'b1; out1_ready = 1'b1;
        drive(1, 0, 8'hA5);
        chk("route_rdy0", in_ready, 1);
        tick();
        chk("route_v0", out0_valid, 1);
        chk("route_d0", out0_data, 8'hA5);
        drive(1, 1, 8'h3C);
        tick();
        chk("route_v1", out1_valid, 1);
        chk("route_d1", out1_data, 8'h3C);
        chk("route_v0_drained", out0_valid, 0);
        chk("route_cnt0", cnt0, 1);
        drive(0, 0, 8'h00);
        tick();
        chk("route_cnt1", cnt1, 1);
        chk("route_v1_drained", out1_valid, 0);

        // Fill channel 0 under backpressure
        out0_ready = 1'b0;
        drive(1, 0, 8'h01); tick();
        drive(1, 0, 8'h02); tick();
        drive(1, 0, 8'h03);
        chk("full_rdy0", in_ready, 0);
        tick();
        chk("full_hold_d0", out0_data, 8'h01);
        chk("full_cnt0", cnt0, 1);

        // Channel 1 unaffected by the stalled, full channel 0
        drive(1, 1, 8'h55);
        chk("indep_rdy1", in_ready, 1);
        tick();
        drive(0, 0, 8'h00);
        chk("indep_v1", out1_valid, 1);
        chk("indep_d1", out1_data, 8'h55);
        chk("indep_d0", out0_data, 8'h01);
        tick();
        chk("indep_cnt1", cnt1, 2);

        // Drain channel 0; no pass-through while full
        out0_ready = 1'b1;
        drive(1, 0, 8'h03);
        chk("nopass_rdy0", in_ready, 0);
        tick();
        chk("drain_d0_02", out0_data, 8'h02);
        chk("drain_cnt0_a", cnt0, 2);
        chk("drain_rdy0", in_ready, 1);
        tick();
        drive(0, 0, 8'h00);
        chk("drain_d0_03", out0_data, 8'h03);
        chk("drain_cnt0_b", cnt0, 3);
        tick();
        chk("drain_cnt0_c", cnt0, 4);
        chk("drain_v0", out0_valid, 0);

        // Simultaneous push/pop on channel 1 holding one entry
        out1_ready = 1'b0;
        drive(1, 1, 8'h11); tick();
        out1_ready = 1'b1;
        drive(1, 1, 8'h22);
        chk("pp_rdy1", in_ready, 1);
        tick();
        drive(0, 0, 8'h00);
        chk("pp_v1", out1_valid, 1);
        chk("pp_d1", out1_data, 8'h22);
        chk("pp_cnt1", cnt1, 3);
        drive(0, 1, 8'h00);
        chk("pp_rdy1_notfull", in_ready, 1);
        tick();
        chk("pp_cnt1_b", cnt1, 4);
        chk("pp_v1_empty", out1_valid, 0);

        // Clean slate, then 300 back-to-back alternating beats
        rst_n = 1'b0; #1; rst_n = 1'b1;
        chk("rst2_cnt0", cnt0, 0);
        for (int i = 0; i < 300; i++) begin
            drive(1, i[0], i[7:0]);
            chk("tp_rdy", in_ready, 1);
            tick();
            if (i[0]) chk("tp_d1", out1_data, i[7:0]);
            else      chk("tp_d0", out0_data, i[7:0]);
        end
        drive(0, 0, 8'h00);
        tick();
        chk("tp_cnt0", cnt0, 150);
        chk("tp_cnt1", cnt1, 150);

        // Async reset with two beats buffered per channel
        out0_ready = 1'b0; out1_ready = 1'b0;
        drive(1, 0, 8'h81); tick();
        drive(1, 1, 8'h82); tick();
        drive(1, 0, 8'h83); tick();
        drive(1, 1, 8'h84); tick();
        drive(0, 0, 8'h00);
        chk("pre_rst_v0", out0_valid, 1);
        chk("pre_rst_v1", out1_valid, 1);
        chk("pre_rst_full0", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_v0", out0_valid, 0);
        chk("arst_v1", out1_valid, 0);
        chk("arst_cnt0", cnt0, 0);
        chk("arst_cnt1", cnt1, 0);
        chk("arst_rdy", in_ready, 0);
        chk("arst_d1", out1_data, 0);
        rst_n = 1'b1;
        out0_ready = 1'b1; out1_ready = 1'b1;
        drive(1, 0, 8'h99);
        tick();
        drive(0, 0, 8'h00);
        chk("post_rst_d0", out0_data, 8'h99);
        chk("post_rst_v1", out1_valid, 0);
        tick();
        chk("post_rst_cnt0", cnt0, 1);
        chk("post_rst_cnt1", cnt1, 0);
        chk("post_rst_v0", out0_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
